fc_seq: RTL and testbench

FC_SEQ -- requirements
Module: fc_seq

---
 rtl/fc_seq_if.sv | 17 +
 rtl/fc_seq.sv | 84 ++++++++
 tb/tb_fc_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_seq_if.sv
// fc_seq_if: request/response handshake and fc-side bundle for fc_seq
interface fc_seq_if #(parameter int N = 27);
  logic req_valid, req_ready, req_train;
  logic [N-1:0] req_fin, req_bin;
  logic fd_prop, bk_prop, fd_prop_done, bk_prop_done, oscillator;
  logic [N-1:0] fin, bin, fout, bout;
  logic rsp_valid, rsp_ready, rsp_timeout;
  logic [N-1:0] rsp_fout, rsp_bout;
  modport slave (
    input  req_valid, req_train, req_fin, req_bin, fd_prop_done, bk_prop_done, fout, bout, rsp_ready,
    output req_ready, fd_prop, bk_prop, fin, bin, oscillator, rsp_valid, rsp_timeout, rsp_fout, rsp_bout
  );
  modport master (
    output req_valid, req_train, req_fin, req_bin, fd_prop_done, bk_prop_done, fout, bout, rsp_ready,
    input  req_ready, fd_prop, bk_prop, fin, bin, oscillator, rsp_valid, rsp_timeout, rsp_fout, rsp_bout
  );
endinterface

// File: rtl/fc_seq.sv
// fc_seq: sequences fc forward/backward propagation with timeout and response handshake
module fc_seq #(
  parameter int N = 27,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  fc_seq_if.slave     s,
  output logic        busy,
  output logic [15:0] iter_count
);
  typedef enum logic [2:0] {IDLE, FWD, FWAIT, BWD, BWAIT, RESP} state_t;
  state_t state;
  logic train;
  logic [15:0] cnt;
  logic tmo;
  assign tmo = cnt == 16'(TIMEOUT - 1);
  assign s.req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      train <= 1'b0;
      cnt <= '0;
      iter_count <= '0;
      s.fd_prop <= 1'b0;
      s.bk_prop <= 1'b0;
      s.fin <= '0;
      s.bin <= '0;
      s.oscillator <= 1'b0;
      s.rsp_valid <= 1'b0;
      s.rsp_timeout <= 1'b0;
      s.rsp_fout <= '0;
      s.rsp_bout <= '0;
    end else begin
      s.oscillator <= !s.oscillator;
      s.fd_prop <= 1'b0;
      s.bk_prop <= 1'b0;
      case (state)
        IDLE: if (s.req_valid) begin
          state <= FWD;
          s.fd_prop <= 1'b1;
          s.fin <= s.req_fin;
          s.bin <= s.req_bin;
          train <= s.req_train;
          s.rsp_fout <= '0;
          s.rsp_bout <= '0;
          s.rsp_timeout <= 1'b0;
        end
        FWD: begin
          state <= FWAIT;
          cnt <= '0;
        end
        FWAIT: if (s.fd_prop_done) begin
          s.rsp_fout <= s.fout;
          state <= train ? BWD : RESP;
          s.bk_prop <= train;
          s.rsp_valid <= !train;
        end else if (tmo) begin
          state <= RESP;
          s.rsp_valid <= 1'b1;
          s.rsp_timeout <= 1'b1;
        end else cnt <= cnt + 16'd1;
        BWD: begin
          state <= BWAIT;
          cnt <= '0;
        end
        BWAIT: if (s.bk_prop_done || tmo) begin
          // done wins over a timeout landing in the same cycle
          if (s.bk_prop_done) s.rsp_bout <= s.bout;
          s.rsp_timeout <= !s.bk_prop_done;
          state <= RESP;
          s.rsp_valid <= 1'b1;
        end else cnt <= cnt + 16'd1;
        RESP: if (s.rsp_ready) begin
          state <= IDLE;
          s.rsp_valid <= 1'b0;
          if (train && !s.rsp_timeout && iter_count != 16'hFFFF) iter_count <= iter_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_seq.sv
// tb_fc_seq: scoreboard-driven bench for fc_seq with a scripted fc responder
module tb_fc_seq;
  localparam int N = 27;
  localparam int TO = 8;
  typedef struct {logic [N-1:0] f; logic [N-1:0] b; logic to;} exp_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic busy;
  logic [15:0] iter_count;
  fc_seq_if #(.N(N)) bus();
  fc_seq #(.N(N), .TIMEOUT(TO)) dut (.clk_in(clk_in), .rst_in(rst_in), .s(bus), .busy(busy), .iter_count(iter_count));
  always #5 clk_in = !clk_in;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int fdc, bkc, both, lat;
  logic got_rsp, stable, rdy_bad, busy_after, obs_to;
  logic [N-1:0] obs_fout, obs_bout, obs_fin, obs_bin;
  logic [15:0] exp_iter = 16'd0;

  task automatic drive_op(input logic tr, input logic [N-1:0] fi, bi, fo, bo, input int fd, bd, hold, input logic early);
    int tf, tk;
    tf = -1; tk = -1; fdc = 0; bkc = 0; both = 0; lat = 1;
    got_rsp = 0; stable = 1; rdy_bad = 0;
    bus.req_valid = 1; bus.req_train = tr; bus.req_fin = fi; bus.req_bin = bi; bus.fout = fo; bus.bout = bo;
    @(negedge clk_in);
    bus.req_valid = 0; bus.req_fin = ~fi; bus.req_bin = ~bi;
    for (int c = 0; c < 100; c++) begin
      if (bus.rsp_valid) begin got_rsp = 1; break; end
      if (bus.fd_prop) begin fdc++; tf = fd; end
      if (bus.bk_prop) begin bkc++; tk = bd; end
      if (bus.fd_prop && bus.bk_prop) both++;
      bus.fd_prop_done = tf == 0;
      bus.bk_prop_done = tk == 0;
      if (tf >= 0) tf--;
      if (tk >= 0) tk--;
      @(negedge clk_in);
      lat++;
    end
    obs_fout = bus.rsp_fout; obs_bout = bus.rsp_bout; obs_to = bus.rsp_timeout;
    obs_fin = bus.fin; obs_bin = bus.bin;
    for (int c = 0; c < hold; c++) begin
      bus.fd_prop_done = c[0]; bus.bk_prop_done = !c[0]; bus.fout = ~fo; bus.bout = ~bo;
      if (bus.req_ready) rdy_bad = 1;
      @(negedge clk_in);
      if (!bus.rsp_valid || bus.rsp_fout !== obs_fout || bus.rsp_bout !== obs_bout || bus.rsp_timeout !== obs_to) stable = 0;
    end
    bus.fd_prop_done = 0; bus.bk_prop_done = 0;
    if (bus.req_ready) rdy_bad = 1;
    bus.rsp_ready = 1;
    if (early) bus.req_valid = 1;
    @(negedge clk_in);
    bus.rsp_ready = 0;
    busy_after = busy;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_chk++; if ({bus.fd_prop, bus.bk_prop, bus.rsp_valid, bus.rsp_timeout, bus.oscillator} !== 5'b0) begin n_fail++; $display("FAIL rst_flags got %b want 00000", {bus.fd_prop, bus.bk_prop, bus.rsp_valid, bus.rsp_timeout, bus.oscillator}); end
    n_chk++; if (iter_count !== 16'd0) begin n_fail++; $display("FAIL rst_iter got %h want 0000", iter_count); end
    rst_in = 0;
    @(negedge clk_in);
    n_chk++; if (bus.oscillator !== 1'b1) begin n_fail++; $display("FAIL osc_first got %b want 1", bus.oscillator); end
    @(negedge clk_in);
    n_chk++; if (bus.oscillator !== 1'b0) begin n_fail++; $display("FAIL osc_second got %b want 0", bus.oscillator); end
  endtask

  task automatic test_forward();
    exp_t e;
    sb.push_back('{27'h1234567, 27'h0, 1'b0});
    drive_op(0, 27'h5A5A5A5, 27'h0ABCDEF, 27'h1234567, 27'h7654321, 3, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (got_rsp !== 1'b1) begin n_fail++; $display("FAIL fwd_rsp got %b want 1", got_rsp); end
    n_chk++; if (fdc !== 1 || bkc !== 0) begin n_fail++; $display("FAIL fwd_pulses got fd=%0d bk=%0d want fd=1 bk=0", fdc, bkc); end
    n_chk++; if (obs_fout !== e.f || obs_bout !== e.b || obs_to !== e.to) begin n_fail++; $display("FAIL fwd_result got %h/%h/%b want %h/%h/%b", obs_fout, obs_bout, obs_to, e.f, e.b, e.to); end
    n_chk++; if (obs_fin !== 27'h5A5A5A5 || obs_bin !== 27'h0ABCDEF) begin n_fail++; $display("FAIL fwd_fin_hold got %h/%h want 5a5a5a5/0abcdef", obs_fin, obs_bin); end
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL fwd_latency got %0d want 5", lat); end
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL fwd_iter got %h want %h", iter_count, exp_iter); end
    sb.push_back('{27'h0000042, 27'h0, 1'b0});
    drive_op(0, 27'h1, 27'h2, 27'h0000042, 27'h3, 1, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL fwd_min_latency got %0d want 3", lat); end
    n_chk++; if (obs_fout !== e.f || obs_to !== e.to) begin n_fail++; $display("FAIL fwd_min_result got %h/%b want %h/%b", obs_fout, obs_to, e.f, e.to); end
  endtask

  task automatic test_train();
    exp_t e;
    sb.push_back('{27'h3C3C3C3, 27'h2468ACE, 1'b0});
    drive_op(1, 27'h1111111, 27'h2222222, 27'h3C3C3C3, 27'h2468ACE, 2, 2, 0, 0);
    e = sb.pop_front();
    exp_iter = exp_iter + 16'd1;
    n_chk++; if (fdc !== 1 || bkc !== 1 || both !== 0) begin n_fail++; $display("FAIL trn_pulses got fd=%0d bk=%0d both=%0d want 1/1/0", fdc, bkc, both); end
    n_chk++; if (obs_fout !== e.f || obs_bout !== e.b || obs_to !== e.to) begin n_fail++; $display("FAIL trn_result got %h/%h/%b want %h/%h/%b", obs_fout, obs_bout, obs_to, e.f, e.b, e.to); end
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL trn_latency got %0d want 7", lat); end
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL trn_iter got %h want %h", iter_count, exp_iter); end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{27'h0, 27'h0, 1'b1});
    drive_op(0, 27'h7, 27'h8, 27'h5555555, 27'h6, -1, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_to !== e.to) begin n_fail++; $display("FAIL to_fwd_result got %h/%b want %h/%b", obs_fout, obs_to, e.f, e.to); end
    n_chk++; if (lat !== 10) begin n_fail++; $display("FAIL to_fwd_latency got %0d want 10", lat); end
    sb.push_back('{27'h0, 27'h0, 1'b1});
    drive_op(0, 27'h7, 27'h8, 27'h5555555, 27'h6, 0, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_to !== e.to || lat !== 10) begin n_fail++; $display("FAIL to_done_in_fwd got %h/%b lat=%0d want %h/%b lat=10", obs_fout, obs_to, lat, e.f, e.to); end
    sb.push_back('{27'h5555555, 27'h0, 1'b0});
    drive_op(0, 27'h7, 27'h8, 27'h5555555, 27'h6, 8, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_to !== e.to || lat !== 10) begin n_fail++; $display("FAIL to_done_wins got %h/%b lat=%0d want %h/%b lat=10", obs_fout, obs_to, lat, e.f, e.to); end
    sb.push_back('{27'h0, 27'h0, 1'b1});
    drive_op(0, 27'h7, 27'h8, 27'h5555555, 27'h6, 9, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_to !== e.to || lat !== 10) begin n_fail++; $display("FAIL to_done_late got %h/%b lat=%0d want %h/%b lat=10", obs_fout, obs_to, lat, e.f, e.to); end
    sb.push_back('{27'h0ABCABC, 27'h0, 1'b1});
    drive_op(1, 27'h7, 27'h8, 27'h0ABCABC, 27'h6, 1, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_bout !== e.b || obs_to !== e.to || lat !== 12) begin n_fail++; $display("FAIL to_bwait got %h/%h/%b lat=%0d want %h/%h/%b lat=12", obs_fout, obs_bout, obs_to, lat, e.f, e.b, e.to); end
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL to_iter got %h want %h", iter_count, exp_iter); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    sb.push_back('{27'h6DB6DB6, 27'h0, 1'b0});
    drive_op(0, 27'h3, 27'h4, 27'h6DB6DB6, 27'h1, 1, -1, 10, 0);
    e = sb.pop_front();
    n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", stable); end
    n_chk++; if (rdy_bad !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready_seen got %b want 0", rdy_bad); end
    n_chk++; if (obs_fout !== e.f || obs_bout !== e.b || obs_to !== e.to) begin n_fail++; $display("FAIL bp_result got %h/%h/%b want %h/%h/%b", obs_fout, obs_bout, obs_to, e.f, e.b, e.to); end
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{27'h0F0F0F0, 27'h70F0F0F, 1'b0});
    drive_op(1, 27'h9, 27'hA, 27'h0F0F0F0, 27'h70F0F0F, 1, 1, 0, 1);
    e = sb.pop_front();
    exp_iter = exp_iter + 16'd1;
    n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept_in_handshake got busy=%b want 0", busy_after); end
    n_chk++; if (obs_fout !== e.f || obs_bout !== e.b || lat !== 5) begin n_fail++; $display("FAIL b2b_first got %h/%h lat=%0d want %h/%h lat=5", obs_fout, obs_bout, lat, e.f, e.b); end
    sb.push_back('{27'h1357913, 27'h0, 1'b0});
    drive_op(0, 27'hB, 27'hC, 27'h1357913, 27'h5, 2, -1, 0, 0);
    e = sb.pop_front();
    n_chk++; if (obs_fout !== e.f || obs_fin !== 27'hB || lat !== 4) begin n_fail++; $display("FAIL b2b_second got %h fin=%h lat=%0d want %h fin=000000b lat=4", obs_fout, obs_fin, lat, e.f); end
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL b2b_iter got %h want %h", iter_count, exp_iter); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.req_valid = 1; bus.req_train = 1; bus.req_fin = 27'h1ABCDEF; bus.req_bin = 27'h0FEDCBA; bus.fout = 27'h1; bus.bout = 27'h2;
    @(negedge clk_in);
    bus.req_valid = 0;
    @(negedge clk_in);
    bus.fd_prop_done = 1;
    @(negedge clk_in);
    bus.fd_prop_done = 0;
    n_chk++; if (bus.bk_prop !== 1'b1) begin n_fail++; $display("FAIL rm_bwd got bk_prop=%b want 1", bus.bk_prop); end
    @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    exp_iter = 16'd0;
    n_chk++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle got ready=%b busy=%b want 1/0", bus.req_ready, busy); end
    n_chk++; if ({bus.fd_prop, bus.bk_prop, bus.rsp_valid, bus.rsp_timeout, bus.oscillator} !== 5'b0) begin n_fail++; $display("FAIL rm_flags got %b want 00000", {bus.fd_prop, bus.bk_prop, bus.rsp_valid, bus.rsp_timeout, bus.oscillator}); end
    n_chk++; if (bus.rsp_fout !== 27'h0 || bus.rsp_bout !== 27'h0 || bus.fin !== 27'h0 || bus.bin !== 27'h0) begin n_fail++; $display("FAIL rm_data got %h/%h/%h/%h want all 0", bus.rsp_fout, bus.rsp_bout, bus.fin, bus.bin); end
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL rm_iter got %h want %h", iter_count, exp_iter); end
    rst_in = 0;
    seen = 0;
    bus.bk_prop_done = 1;
    repeat (5) begin
      @(negedge clk_in);
      bus.bk_prop_done = 0;
      if (bus.rsp_valid) seen = 1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_no_response got rsp_valid seen=%b want 0", seen); end
  endtask

  task automatic test_saturate();
    force dut.iter_count = 16'hFFFE;
    @(negedge clk_in);
    release dut.iter_count;
    @(negedge clk_in);
    exp_iter = 16'hFFFE;
    n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL sat_preload got %h want %h", iter_count, exp_iter); end
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{27'h0000011, 27'h0000022, 1'b0});
      drive_op(1, 27'h1, 27'h2, 27'h0000011, 27'h0000022, 1, 1, 0, 0);
      void'(sb.pop_front());
      exp_iter = 16'hFFFF;
      n_chk++; if (iter_count !== exp_iter) begin n_fail++; $display("FAIL sat_iter_%0d got %h want %h", k, iter_count, exp_iter); end
    end
    n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_train = 0; bus.req_fin = '0; bus.req_bin = '0;
    bus.fd_prop_done = 0; bus.bk_prop_done = 0; bus.fout = '0; bus.bout = '0; bus.rsp_ready = 0;
    test_reset();
    test_forward();
    test_train();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
